cpubus_arb: RTL and testbench
=============================

# cpubus_arb

Parametrised CPU-bus arbiter that replaces the hard-wired debugger > sprite-DMA > CPU priority mux in the top level. It grants one of `NUM_MASTERS` requesters the shared CPU memory bus (address, R/!W, write data, enable). Handover is registered with a one-cycle idle bubble, and preemption is selectable per master. It forms read data by OR-reducing `NUM_SLAVES` slave outputs, which return 0 when not addressed. It sits between the CPU, sprite DMA and debug blocks on one side and cart, WRAM, PPU register and joypad blocks on the other.

## Interface
Parameters:
- `NUM_MASTERS`, default 3. Number of requesters. Index 0 is the default master (CPU); a higher index means higher priority.
- `NUM_SLAVES`, default 4. Number of read-data sources that are OR-reduced.
- `ADDR_W`, default 16. Address width.
- `DATA_W`, default 8. Data width.
- `PREEMPT_MASK`, default `'b100`. Bit i set means master i may preempt a lower-index owner.

Ports:
- `clk_in`, in, 1. System clock.
- `nrst_in`, in, 1. Asynchronous, active-low reset.
- `m_req_in`, in, `NUM_MASTERS`. Request per master. Bit 0 is ignored; the default master always wants the bus.
- `m_a_in`, in, `NUM_MASTERS*ADDR_W`. Packed master addresses; master i occupies slice i.
- `m_r_nw_in`, in, `NUM_MASTERS`. R/!W per master.
- `m_d_in`, in, `NUM_MASTERS*DATA_W`. Packed write data.
- `m_gnt_out`, out, `NUM_MASTERS`. One-hot registered grant, or all zero during a bubble.
- `m_d_out`, out, `DATA_W`. Read data, broadcast to all masters.
- `s_d_in`, in, `NUM_SLAVES*DATA_W`. Packed slave read data.
- `bus_a_out`, out, `ADDR_W`. Shared bus address.
- `bus_r_nw_out`, out, 1. Shared bus R/!W.
- `bus_d_out`, out, `DATA_W`. Shared bus write data.
- `bus_en_out`, out, 1. Bus cycle valid. Slaves must not act when this is 0.
- `owner_out`, out, `$clog2(NUM_MASTERS+1)`. Current owner index, or `NUM_MASTERS` for NONE.

## Operation
- The owner register `owner_q` holds a value in 0..`NUM_MASTERS`-1 or NONE. Reset value is 0; the default master owns the bus out of reset.
- Reset values of the outputs:
  - `m_gnt_out = 1`.
  - `bus_en_out = 1`.
  - `owner_out = 0`.
  - Bus outputs follow master 0.
- When owner is OWNED(k):
  - `bus_*` are driven from master k.
  - `bus_en_out = 1`.
  - `m_gnt_out = 1<<k`.
- When owner is NONE (bubble):
  - `bus_en_out = 0`.
  - `bus_r_nw_out = 1`.
  - `bus_a_out` and `bus_d_out` are 0.
  - `m_gnt_out = 0`.
- Release from OWNED(k), k≠0, to NONE happens when `m_req_in[k]` is 0.
- Preemption from OWNED(k) to NONE happens when some j>k with `PREEMPT_MASK[j]=1` has `m_req_in[j]=1`.
- Owner 0 is released as soon as any `m_req_in[j]` with j≥1 is set. The default master never blocks.
- NONE moves to OWNED(p), where p is the highest index with its req set at that edge. If no req is set, p is 0.
- Non-preemptive masters wait for release, even if they have higher priority than the owner.
- `m_d_out` is the bitwise OR of all `s_d_in` slices. It is combinational and independent of owner.

## Timing
- The grant changes only on `clk_in` rising edges. The bus mux is combinational from `owner_q`.
- Handover latency, from the request or release edge to the new owner granted, is exactly 2 cycles: 1 bubble plus 1.
- Default master 0 regaining the bus after a release also passes through 1 bubble.
- Simultaneous events:
  - If the owner drops req and a preempting req arrives in the same cycle, there is a single bubble and p is chosen at the end of the bubble.
  - If a pending req drops during the bubble, the arbiter falls back to the next highest request, or to 0.
- Reset asserted mid-transfer forces owner 0 immediately (asynchronously). No bubble occurs on deassertion.
- There is no combinational path from `m_req_in` to `m_gnt_out`.

## Structure
- Shared package `cpubus_pkg`:
  - `OWNER_NONE` constant.
  - `owner_t` width helper.
  - `prio_pick` function (highest set index, with an eligibility mask).
- Sub-module `cpubus_prio_enc`: parametrised highest-index priority encoder with valid output. It is used for both the preempt check and the NONE→owner choice.
- The OR-reduce for read data and the bus mux are generate loops inside `cpubus_arb`.

## Test plan
All scenarios use N=3, S=4, `PREEMPT_MASK=3'b100`.
- **Reset:** hold `nrst_in=0`, then release → `m_gnt_out=3'b001`, `bus_en_out=1`, and `bus_a_out` equals the master-0 address `16'hC000`.
- **DMA request:** raise `m_req_in[1]` at cycle 0 → at cycle 1 `gnt=000` and `bus_en=0`; at cycle 2 `gnt=010` and `bus_a` equals master 1's `16'h0200`. Drop req at cycle 10 → cycle 11 is a bubble and cycle 12 has `gnt=001`.
- **Debug preempts DMA:** while master 1 owns the bus, raise `m_req_in[2]` → bubble on the next cycle, then `gnt=100`. Master 1 keeps its req high and regains the bus 2 cycles after `req[2]` drops.
- **Non-preemptive wait:** use `PREEMPT_MASK=0`, master 1 owns the bus, raise req[2] → `gnt` stays `010` until req[1] drops, then bubble, then `100`.
- **Read OR:** drive `s_d_in` slices `8'h00, 8'h5A, 8'h00, 8'h00` → `m_d_out=8'h5A`. Drive slices `8'h01, 8'h02` → `m_d_out=8'h03`.
- **Async reset mid-grant:** while master 2 owns the bus, pulse `nrst_in` low between clock edges → `gnt=001` immediately, with no bubble after release.

Source files
------------

// File: rtl/cpubus_pkg.sv
// ============================================================================
// cpubus_pkg : shared owner encoding helpers and priority pick for the CPU bus arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package cpubus_pkg;

   localparam int unsigned PICK_W = 32;

   // Width of an owner index able to hold 0..n-1 plus the NONE code.
   function automatic int unsigned owner_w(input int unsigned n);
      return $clog2(n + 1);
   endfunction

   // NONE is encoded as the first index past the last master.
   function automatic int unsigned owner_none(input int unsigned n);
      return n;
   endfunction

   // Highest index set in req that is also eligible; -1 when nothing qualifies.
   function automatic int prio_pick(input logic [PICK_W-1:0] req,
                                    input logic [PICK_W-1:0] elig);
      int pick;
      pick = -1;
      for (int i = 0; i < PICK_W; i++) begin
         if (req[i] && elig[i]) pick = i;
      end
      return pick;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpubus_prio_enc.sv
// ============================================================================
// cpubus_prio_enc : highest-index priority encoder over an eligibility mask
// Rev 1.0
// ============================================================================
`default_nettype none

module cpubus_prio_enc
   import cpubus_pkg::*;
#(
   parameter int unsigned  W     = 3,
   parameter int unsigned  IDX_W = 2,
   parameter logic [W-1:0] ELIG  = '1
)(
   input  logic [W-1:0]     req_in,
   output logic [IDX_W-1:0] idx_out,
   output logic             valid_out
);

   int pick;

   always_comb begin
      pick      = prio_pick(PICK_W'(req_in), PICK_W'(ELIG));
      valid_out = (pick >= 0);
      idx_out   = valid_out ? IDX_W'(pick) : '0;
   end

endmodule

`default_nettype wire

// File: rtl/cpubus_arb.sv
// ============================================================================
// cpubus_arb : shared CPU bus arbiter with idle-bubble handover and per-master preemption
// Rev 1.0
// ============================================================================
`default_nettype none

module cpubus_arb
   import cpubus_pkg::*;
#(
   parameter int unsigned            NUM_MASTERS  = 3,
   parameter int unsigned            NUM_SLAVES   = 4,
   parameter int unsigned            ADDR_W       = 16,
   parameter int unsigned            DATA_W       = 8,
   parameter logic [NUM_MASTERS-1:0] PREEMPT_MASK = 'b100
)(
   input  logic                                  clk_in,
   input  logic                                  nrst_in,
   input  logic [NUM_MASTERS-1:0]                m_req_in,
   input  logic [NUM_MASTERS*ADDR_W-1:0]         m_a_in,
   input  logic [NUM_MASTERS-1:0]                m_r_nw_in,
   input  logic [NUM_MASTERS*DATA_W-1:0]         m_d_in,
   output logic [NUM_MASTERS-1:0]                m_gnt_out,
   output logic [DATA_W-1:0]                     m_d_out,
   input  logic [NUM_SLAVES*DATA_W-1:0]          s_d_in,
   output logic [ADDR_W-1:0]                     bus_a_out,
   output logic                                  bus_r_nw_out,
   output logic [DATA_W-1:0]                     bus_d_out,
   output logic                                  bus_en_out,
   output logic [$clog2(NUM_MASTERS+1)-1:0]      owner_out
);

   localparam int unsigned            OWN_W      = owner_w(NUM_MASTERS);
   localparam logic [OWN_W-1:0]       OWNER_NONE = OWN_W'(owner_none(NUM_MASTERS));
   // The default master never competes for a new grant; it is the fallback.
   localparam logic [NUM_MASTERS-1:0] SEL_ELIG   = {{(NUM_MASTERS-1){1'b1}}, 1'b0};

   logic [OWN_W-1:0] owner_q, owner_d;
   logic [OWN_W-1:0] pre_idx, sel_idx;
   logic             pre_valid, sel_valid;

   cpubus_prio_enc #(
      .W     (NUM_MASTERS),
      .IDX_W (OWN_W),
      .ELIG  (PREEMPT_MASK)
   ) u_pre_enc (
      .req_in    (m_req_in),
      .idx_out   (pre_idx),
      .valid_out (pre_valid)
   );

   cpubus_prio_enc #(
      .W     (NUM_MASTERS),
      .IDX_W (OWN_W),
      .ELIG  (SEL_ELIG)
   ) u_sel_enc (
      .req_in    (m_req_in),
      .idx_out   (sel_idx),
      .valid_out (sel_valid)
   );

   always_comb begin
      owner_d = owner_q;
      if (owner_q == OWNER_NONE) begin
         owner_d = sel_valid ? sel_idx : '0;
      end else if (owner_q == '0) begin
         if (sel_valid) owner_d = OWNER_NONE;
      end else if (!m_req_in[owner_q] || (pre_valid && (pre_idx > owner_q))) begin
         owner_d = OWNER_NONE;
      end
   end

   always_ff @(posedge clk_in or negedge nrst_in) begin
      if (!nrst_in) owner_q <= '0;
      else          owner_q <= owner_d;
   end

   logic [NUM_MASTERS-1:0] gnt;
   logic [ADDR_W-1:0]      a_sel  [NUM_MASTERS];
   logic [DATA_W-1:0]      d_sel  [NUM_MASTERS];
   logic [DATA_W-1:0]      rd_sel [NUM_SLAVES];
   logic [ADDR_W-1:0]      bus_a;
   logic [DATA_W-1:0]      bus_d;
   logic [DATA_W-1:0]      rd_or;

   for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_bus_mux
      assign gnt[i]   = (owner_q == OWN_W'(i));
      assign a_sel[i] = gnt[i] ? m_a_in[i*ADDR_W +: ADDR_W] : '0;
      assign d_sel[i] = gnt[i] ? m_d_in[i*DATA_W +: DATA_W] : '0;
   end

   // Unaddressed slaves drive zero, so a plain OR merges the read data.
   for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_rd_or
      assign rd_sel[s] = s_d_in[s*DATA_W +: DATA_W];
   end

   always_comb begin
      bus_a = '0;
      bus_d = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         bus_a = bus_a | a_sel[i];
         bus_d = bus_d | d_sel[i];
      end
      rd_or = '0;
      for (int s = 0; s < NUM_SLAVES; s++) begin
         rd_or = rd_or | rd_sel[s];
      end
   end

   assign m_gnt_out    = gnt;
   assign bus_a_out    = bus_a;
   assign bus_d_out    = bus_d;
   assign bus_en_out   = (owner_q != OWNER_NONE);
   // A bubble presents a harmless read cycle.
   assign bus_r_nw_out = (owner_q == OWNER_NONE) | (|(gnt & m_r_nw_in));
   assign m_d_out      = rd_or;
   assign owner_out    = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_cpubus_arb.sv
// ============================================================================
// tb_cpubus_arb : directed and random checks of cpubus_arb against a rule-level model
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpubus_arb;

   localparam int N  = 3;
   localparam int S  = 4;
   localparam int AW = 16;
   localparam int DW = 8;

   logic            clk  = 1'b0;
   logic            nrst = 1'b0;
   logic [N-1:0]    req  = '0;
   logic [N-1:0]    rnw  = '0;
   logic [N*AW-1:0] ma   = '0;
   logic [N*DW-1:0] md   = '0;
   logic [S*DW-1:0] sd   = '0;

   logic [N-1:0]  gnt_p, gnt_n;
   logic [DW-1:0] rd_p, rd_n;
   logic [AW-1:0] a_p, a_n;
   logic          r_p, r_n;
   logic [DW-1:0] d_p, d_n;
   logic          en_p, en_n;
   logic [1:0]    own_out_p, own_out_n;

   int checks = 0;
   int errors = 0;
   int own_p  = 0;
   int own_n  = 0;

   always #5 clk = ~clk;

   cpubus_arb #(
      .NUM_MASTERS (N), .NUM_SLAVES (S), .ADDR_W (AW), .DATA_W (DW),
      .PREEMPT_MASK (3'b100)
   ) dut_p (
      .clk_in (clk), .nrst_in (nrst), .m_req_in (req), .m_a_in (ma),
      .m_r_nw_in (rnw), .m_d_in (md), .m_gnt_out (gnt_p), .m_d_out (rd_p),
      .s_d_in (sd), .bus_a_out (a_p), .bus_r_nw_out (r_p), .bus_d_out (d_p),
      .bus_en_out (en_p), .owner_out (own_out_p)
   );

   cpubus_arb #(
      .NUM_MASTERS (N), .NUM_SLAVES (S), .ADDR_W (AW), .DATA_W (DW),
      .PREEMPT_MASK (3'b000)
   ) dut_n (
      .clk_in (clk), .nrst_in (nrst), .m_req_in (req), .m_a_in (ma),
      .m_r_nw_in (rnw), .m_d_in (md), .m_gnt_out (gnt_n), .m_d_out (rd_n),
      .s_d_in (sd), .bus_a_out (a_n), .bus_r_nw_out (r_n), .bus_d_out (d_n),
      .bus_en_out (en_n), .owner_out (own_out_n)
   );

   // Owner as an integer: -1 is the idle bubble, otherwise the master index.
   function automatic int next_owner(input int cur, input logic [N-1:0] r,
                                     input logic [N-1:0] mask);
      if (cur < 0) begin
         for (int j = N-1; j >= 1; j--) if (r[j]) return j;
         return 0;
      end
      if (cur == 0) return (r[N-1:1] != '0) ? -1 : 0;
      if (!r[cur]) return -1;
      for (int j = cur + 1; j < N; j++) if (mask[j] && r[j]) return -1;
      return cur;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_dut(input string tag, input int own, input logic [N-1:0] g,
                            input logic [AW-1:0] a, input logic r, input logic [DW-1:0] d,
                            input logic e, input logic [1:0] o, input logic [DW-1:0] rd);
      logic [N-1:0]  eg;
      logic [AW-1:0] ea;
      logic          er, ee;
      logic [DW-1:0] ed, erd;
      logic [1:0]    eo;
      if (own < 0) begin
         eg = '0; ea = '0; er = 1'b1; ed = '0; ee = 1'b0; eo = 2'd3;
      end else begin
         eg = N'(1 << own);
         ea = ma[own*AW +: AW];
         er = rnw[own];
         ed = md[own*DW +: DW];
         ee = 1'b1;
         eo = 2'(own);
      end
      erd = '0;
      for (int i = 0; i < S; i++) erd = erd | sd[i*DW +: DW];
      chk({tag, ".gnt"},   32'(g),  32'(eg));
      chk({tag, ".bus_a"}, 32'(a),  32'(ea));
      chk({tag, ".r_nw"},  32'(r),  32'(er));
      chk({tag, ".bus_d"}, 32'(d),  32'(ed));
      chk({tag, ".en"},    32'(e),  32'(ee));
      chk({tag, ".owner"}, 32'(o),  32'(eo));
      chk({tag, ".rd"},    32'(rd), 32'(erd));
   endtask

   task automatic check_both(input string tag);
      check_dut({tag, "/p"}, own_p, gnt_p, a_p, r_p, d_p, en_p, own_out_p, rd_p);
      check_dut({tag, "/n"}, own_n, gnt_n, a_n, r_n, d_n, en_n, own_out_n, rd_n);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      if (nrst) begin
         own_p = next_owner(own_p, req, 3'b100);
         own_n = next_owner(own_n, req, 3'b000);
      end else begin
         own_p = 0;
         own_n = 0;
      end
      #1;
      check_both(tag);
   endtask

   task automatic async_reset_pulse(input string tag);
      #1 nrst = 1'b0;
      #1;
      own_p = 0;
      own_n = 0;
      chk({tag, ".gnt_now"}, 32'(gnt_p), 32'h1);
      check_both(tag);
      #1 nrst = 1'b1;
   endtask

   initial begin
      ma  = {16'h4016, 16'h0200, 16'hC000};
      md  = {8'hD2, 8'hD1, 8'hD0};
      rnw = 3'b101;

      repeat (3) @(posedge clk);
      #1;
      check_both("reset");
      chk("reset.gnt_const", 32'(gnt_p), 32'h1);
      chk("reset.a_const",   32'(a_p),   32'hC000);
      nrst = 1'b1;
      cycle("rst_rel");
      chk("rst_rel.en_const", 32'(en_p), 32'h1);

      req = 3'b010;
      cycle("dma_c1");
      chk("dma_c1.gnt_const", 32'(gnt_p), 32'h0);
      cycle("dma_c2");
      chk("dma_c2.gnt_const", 32'(gnt_p), 32'h2);
      chk("dma_c2.a_const",   32'(a_p),   32'h0200);
      repeat (8) cycle("dma_hold");
      req = 3'b000;
      cycle("dma_rel1");
      chk("dma_rel1.en_const", 32'(en_p), 32'h0);
      cycle("dma_rel2");
      chk("dma_rel2.gnt_const", 32'(gnt_p), 32'h1);

      req = 3'b010;
      repeat (3) cycle("pre_setup");
      req = 3'b110;
      cycle("pre_bub");
      chk("pre_bub.gnt_p", 32'(gnt_p), 32'h0);
      chk("pre_bub.gnt_n", 32'(gnt_n), 32'h2);
      cycle("pre_own");
      chk("pre_own.gnt_p", 32'(gnt_p), 32'h4);
      repeat (3) cycle("pre_hold");
      req = 3'b010;
      cycle("pre_rel1");
      cycle("pre_rel2");
      chk("pre_rel2.gnt_p", 32'(gnt_p), 32'h2);

      req = 3'b110;
      repeat (4) cycle("np_wait");
      chk("np_wait.gnt_n", 32'(gnt_n), 32'h2);
      req = 3'b100;
      cycle("np_bub");
      chk("np_bub.gnt_n", 32'(gnt_n), 32'h0);
      cycle("np_own");
      chk("np_own.gnt_n", 32'(gnt_n), 32'h4);

      req = 3'b000;
      async_reset_pulse("arst");
      cycle("arst_post");
      chk("arst_post.en_const", 32'(en_p), 32'h1);

      sd = {8'h00, 8'h00, 8'h5A, 8'h00};
      #1 chk("rd_or_5a", 32'(rd_p), 32'h5A);
      sd = {8'h00, 8'h00, 8'h02, 8'h01};
      #1 chk("rd_or_03", 32'(rd_p), 32'h03);
      cycle("rd_cyc");

      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom);
         ma  = {16'($urandom), 16'($urandom), 16'($urandom)};
         md  = {8'($urandom), 8'($urandom), 8'($urandom)};
         rnw = N'($urandom);
         sd  = {$urandom};
         if ($urandom_range(0, 63) == 0) async_reset_pulse("rnd_arst");
         cycle("rnd");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
